pwm_center3: RTL and testbench
==============================

// Module: pwm_center3
// PURPOSE
//  Three-phase center-aligned PWM generator for the PMSM drive. Runs a triangle
//  carrier and compares it with per-phase shadowed duty values to produce
//  complementary high/low gate requests per phase. Each of the six outputs
//  feeds one deadband stage that delays its rising edge, so pwm_xh/pwm_xl carry
//  no dead time. Also provides a latched fault shutdown and a zero-sync pulse
//  for ADC triggering.
// PARAMETERS
//  CW   16    counter/duty width, bits
//  PRD  2500  carrier half-period in sysclk cycles; PWM period = 2*PRD; 2 <= PRD < 2**CW
// PORTS
//  sysclk      in   1   system clock, all logic on rising edge
//  global_rst  in   1   asynchronous active-low reset
//  en          in   1   1 = carrier runs; 0 = idle, all outputs low
//  duty_a/b/c  in   CW  requested high-side on-time per phase (0..PRD)
//  duty_ld     in   1   1-cycle strobe; captures duty_a/b/c into pending regs
//  fault       in   1   active-high trip request (synchronous to sysclk)
//  fault_clr   in   1   1-cycle strobe; clears latched fault
//  pwm_ah/al   out  1   phase A high/low gate request (to deadband)
//  pwm_bh/bl   out  1   phase B high/low gate request
//  pwm_ch/cl   out  1   phase C high/low gate request
//  sync_zero   out  1   1-cycle pulse, carrier at 0 (period start)
//  duty_ack    out  1   1-cycle pulse, pending duties moved to active
//  fault_lat   out  1   latched fault status
//  cnt         out  CW  carrier value (debug/ADC timing)
// BEHAVIOUR
//  Reset: cnt=0, dir=up, active/pending duties=0, pend=0. All outputs 0.
//  Carrier (en=1): up phase cnt 0..PRD-1 (+1/cycle); from PRD-1 -> cnt=PRD,
//   dir=down. Down phase cnt PRD..1 (-1/cycle); from 1 -> cnt=0, dir=up.
//   Each period is exactly 2*PRD cycles.
//  en=0: cnt forced 0, dir=up, all six pwm outputs 0. The counter resumes from 0
//   on the first cycle en=1.
//  Duty capture: duty_ld=1 loads pending_x = min(duty_x, PRD) and sets pend.
//   Values above PRD clamp to PRD.
//  Transfer: on the edge where cnt leaves 1 in the down phase, or on any cycle
//   with en=0, and only if pend=1: active_x <= pending_x, pend <= 0, duty_ack=1
//   for the next cycle. The new duty governs the whole next period, starting at cnt=0.
//  duty_ld on the same cycle as a transfer: the old pending is transferred; the
//   new value becomes pending and pend stays 1.
//  Compare (registered, 1-cycle latency from cnt/dir): on = (dir up & cnt < active_x)
//   | (dir down & cnt <= active_x). This gives exactly 2*active_x high cycles per
//   period, centered on cnt=0. active=0 -> always off; active=PRD -> always on.
//  pwm_xh = on; pwm_xl = ~on. Both are forced to 0 when en=0 or fault_lat=1, or
//   when fault=1 in the current cycle. All six go low on the same edge that sets fault_lat.
//  Fault: fault=1 sets fault_lat. fault_clr with fault=0 clears it.
//   fault_clr with fault=1 leaves it set (fault wins). The carrier and duty
//   transfer keep running while faulted. Outputs resume from the compare on the
//   edge after the clear.
//  sync_zero: registered, =1 for the one cycle after cnt==0 with en=1.
//  cnt output equals the internal carrier register.
//  Reset mid-operation: all registers return to reset values immediately. Any
//   pending duty is discarded.
// TESTING
//  PRD=10, duty_a=5 loaded with en=0, then en=1 -> pwm_ah high 10 of every 20
//   cycles, symmetric about cnt=0; pwm_al is its exact complement.
//  duty 0 / 10 / 15 -> pwm_ah constant 0 / constant 1 / constant 1 (clamp to PRD).
//  duty_ld a=3->7 at cnt=4 in the up phase -> output unchanged until the period
//   end; duty_ack pulses once; the next period has 14 high cycles.
//  fault=1 for 1 cycle mid-pulse -> all six outputs 0 next edge, fault_lat=1.
//   fault_clr with fault=1 -> stays latched; fault_clr with fault=0 -> outputs resume.
//  en 1->0 mid-period -> outputs 0 and cnt=0 next edge; sync_zero pulses every
//   20 cycles while en=1.
//  global_rst low mid-period with pend=1 -> outputs and cnt 0 immediately;
//   after release, active duty=0 and pend=0.

Source files
------------

// File: rtl/pwm_center3.sv
// pwm_center3 -- three-phase center-aligned PWM generator.
//
// A triangle carrier (0 -> PRD -> 0, period 2*PRD) is compared against
// per-phase active duty registers to form complementary high/low gate
// requests. Duty values are double-buffered: duty_ld captures them into
// pending registers, and they move to the active registers at the end of a
// carrier period (or at any time while idle), so a period is never split
// between two duty values. A latched fault shuts off all six gate requests.
//
// Ports:
//   sysclk       system clock, rising edge
//   global_rst   asynchronous active-low reset
//   en           1 = carrier runs, 0 = idle (counter held at 0, gates off)
//   duty_a/b/c   requested high-side on-time per phase, clamped to PRD
//   duty_ld      strobe: capture duty_a/b/c into the pending registers
//   fault        active-high trip request
//   fault_clr    strobe: clear the latched fault (ignored while fault=1)
//   pwm_xh/xl    phase x high/low gate requests (no dead time applied)
//   sync_zero    1-cycle pulse following carrier = 0
//   duty_ack     1-cycle pulse following a pending -> active transfer
//   fault_lat    latched fault status
//   cnt          carrier value
module pwm_center3 #(
  parameter int unsigned CW  = 16,
  parameter int unsigned PRD = 2500
) (
  input  logic          sysclk,
  input  logic          global_rst,
  input  logic          en,
  input  logic [CW-1:0] duty_a,
  input  logic [CW-1:0] duty_b,
  input  logic [CW-1:0] duty_c,
  input  logic          duty_ld,
  input  logic          fault,
  input  logic          fault_clr,
  output logic          pwm_ah,
  output logic          pwm_al,
  output logic          pwm_bh,
  output logic          pwm_bl,
  output logic          pwm_ch,
  output logic          pwm_cl,
  output logic          sync_zero,
  output logic          duty_ack,
  output logic          fault_lat,
  output logic [CW-1:0] cnt
);

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_t;

  localparam logic [CW-1:0] PRD_V   = CW'(PRD);
  localparam logic [CW-1:0] LAST_UP = CW'(PRD - 1);
  localparam logic [CW-1:0] ONE     = CW'(1);

  dir_t          dir, dir_nxt;
  logic [CW-1:0] cnt_nxt;
  logic [CW-1:0] active       [3];
  logic [CW-1:0] pending      [3];
  logic [CW-1:0] duty_in      [3];
  logic [CW-1:0] duty_clamped [3];
  logic          pend;
  logic          xfer;
  logic          gate;
  logic          fault_lat_nxt;
  logic [2:0]    on;
  logic [2:0]    pwm_h;
  logic [2:0]    pwm_l;

  // Carrier next-state: up 0..PRD-1, turn at PRD, down to 1, wrap to 0.
  always_comb begin
    cnt_nxt = '0;
    dir_nxt = DIR_UP;
    if (en) begin
      unique case (dir)
        DIR_UP: begin
          if (cnt == LAST_UP) begin
            cnt_nxt = PRD_V;
            dir_nxt = DIR_DOWN;
          end else begin
            cnt_nxt = cnt + ONE;
            dir_nxt = DIR_UP;
          end
        end
        DIR_DOWN: begin
          if (cnt == ONE) begin
            cnt_nxt = '0;
            dir_nxt = DIR_UP;
          end else begin
            cnt_nxt = cnt - ONE;
            dir_nxt = DIR_DOWN;
          end
        end
      endcase
    end
  end

  // Compare: strict '<' going up and '<=' going down yields exactly
  // 2*active high cycles per period, centered on cnt = 0.
  always_comb begin
    duty_in[0] = duty_a;
    duty_in[1] = duty_b;
    duty_in[2] = duty_c;
    on         = '0;
    for (int unsigned i = 0; i < 3; i++) begin
      duty_clamped[i] = (duty_in[i] > PRD_V) ? PRD_V : duty_in[i];
      on[i] = (dir == DIR_UP) ? (cnt < active[i]) : (cnt <= active[i]);
    end
  end

  // Transfer at the last cycle of a period (down phase leaving 1) so the new
  // duty starts cleanly at cnt = 0, or at any time while idle.
  always_comb begin
    xfer          = pend & (~en | ((dir == DIR_DOWN) & (cnt == ONE)));
    gate          = en & ~fault & ~fault_lat;
    fault_lat_nxt = fault | (fault_lat & ~fault_clr);
  end

  always_ff @(posedge sysclk or negedge global_rst) begin
    if (!global_rst) begin
      cnt       <= '0;
      dir       <= DIR_UP;
      pend      <= 1'b0;
      duty_ack  <= 1'b0;
      sync_zero <= 1'b0;
      fault_lat <= 1'b0;
      pwm_h     <= '0;
      pwm_l     <= '0;
      for (int unsigned i = 0; i < 3; i++) begin
        active[i]  <= '0;
        pending[i] <= '0;
      end
    end else begin
      cnt       <= cnt_nxt;
      dir       <= dir_nxt;
      // A load coinciding with a transfer keeps pend set for the new value.
      pend      <= duty_ld | (pend & ~xfer);
      duty_ack  <= xfer;
      sync_zero <= en & (cnt == '0);
      fault_lat <= fault_lat_nxt;
      pwm_h     <= {3{gate}} & on;
      pwm_l     <= {3{gate}} & ~on;
      for (int unsigned i = 0; i < 3; i++) begin
        if (xfer) begin
          active[i] <= pending[i];
        end
        if (duty_ld) begin
          pending[i] <= duty_clamped[i];
        end
      end
    end
  end

  assign pwm_ah = pwm_h[0];
  assign pwm_al = pwm_l[0];
  assign pwm_bh = pwm_h[1];
  assign pwm_bl = pwm_l[1];
  assign pwm_ch = pwm_h[2];
  assign pwm_cl = pwm_l[2];

endmodule

// File: tb/tb_pwm_center3.sv
// tb_pwm_center3 -- self-checking bench for pwm_center3 with PRD = 10.
// A position-in-period reference model predicts every registered output;
// predictions are queued when inputs are driven and compared after the edge.
module tb_pwm_center3;

  localparam int unsigned CW  = 16;
  localparam int unsigned PRD = 10;
  localparam int unsigned PER = 2 * PRD;

  logic          sysclk;
  logic          global_rst;
  logic          en;
  logic [CW-1:0] duty_a, duty_b, duty_c;
  logic          duty_ld;
  logic          fault;
  logic          fault_clr;
  logic          pwm_ah, pwm_al, pwm_bh, pwm_bl, pwm_ch, pwm_cl;
  logic          sync_zero;
  logic          duty_ack;
  logic          fault_lat;
  logic [CW-1:0] cnt;

  pwm_center3 #(.CW(CW), .PRD(PRD)) dut (
    .sysclk     (sysclk),
    .global_rst (global_rst),
    .en         (en),
    .duty_a     (duty_a),
    .duty_b     (duty_b),
    .duty_c     (duty_c),
    .duty_ld    (duty_ld),
    .fault      (fault),
    .fault_clr  (fault_clr),
    .pwm_ah     (pwm_ah),
    .pwm_al     (pwm_al),
    .pwm_bh     (pwm_bh),
    .pwm_bl     (pwm_bl),
    .pwm_ch     (pwm_ch),
    .pwm_cl     (pwm_cl),
    .sync_zero  (sync_zero),
    .duty_ack   (duty_ack),
    .fault_lat  (fault_lat),
    .cnt        (cnt)
  );

  initial sysclk = 1'b0;
  always #5 sysclk = ~sysclk;

  typedef struct {
    logic [CW-1:0] cnt;
    logic [2:0]    h;
    logic [2:0]    l;
    logic          sz;
    logic          ack;
    logic          flat;
  } exp_t;

  typedef struct {
    logic [CW-1:0] duty;
    int unsigned   exp_highs;
  } vec_t;

  exp_t        sbq[$];
  vec_t        tbl[7];
  int unsigned vectors;
  int unsigned miscompares;

  // Reference model state: position within the 2*PRD period.
  int unsigned m_pos;
  int unsigned m_act[3];
  int unsigned m_pv[3];
  logic        m_pend;
  logic        m_flat;

  int unsigned highs_a;
  int unsigned syncs;
  int unsigned acks;

  task automatic chk(input string name, input int unsigned act, input int unsigned exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pos  = 0;
    m_pend = 1'b0;
    m_flat = 1'b0;
    for (int i = 0; i < 3; i++) begin
      m_act[i] = 0;
      m_pv[i]  = 0;
    end
  endtask

  // One clock: predict from current inputs, push, clock, pop and compare.
  task automatic tick();
    exp_t        e;
    exp_t        g;
    int unsigned pos_n;
    int unsigned dv[3];
    logic        gate;
    logic        on;
    logic        xfer;
    dv[0] = 32'(duty_a);
    dv[1] = 32'(duty_b);
    dv[2] = 32'(duty_c);
    gate = en && !fault && !m_flat;
    for (int i = 0; i < 3; i++) begin
      on = (m_pos < m_act[i]) || (m_pos >= PER - m_act[i]);
      e.h[i] = gate && on;
      e.l[i] = gate && !on;
    end
    e.sz   = en && (m_pos == 0);
    xfer   = m_pend && (!en || (m_pos == PER - 1));
    e.ack  = xfer;
    m_flat = fault ? 1'b1 : (fault_clr ? 1'b0 : m_flat);
    e.flat = m_flat;
    pos_n  = en ? (m_pos + 1) % PER : 0;
    e.cnt  = CW'((pos_n < PRD) ? pos_n : PER - pos_n);
    if (xfer) begin
      for (int i = 0; i < 3; i++) m_act[i] = m_pv[i];
    end
    if (duty_ld) begin
      for (int i = 0; i < 3; i++) m_pv[i] = (dv[i] > PRD) ? PRD : dv[i];
      m_pend = 1'b1;
    end else if (xfer) begin
      m_pend = 1'b0;
    end
    m_pos = pos_n;
    sbq.push_back(e);

    @(posedge sysclk);
    #1;
    g = sbq.pop_front();
    chk("cnt",       32'(cnt),                      32'(g.cnt));
    chk("pwm_h",     32'({pwm_ch, pwm_bh, pwm_ah}), 32'(g.h));
    chk("pwm_l",     32'({pwm_cl, pwm_bl, pwm_al}), 32'(g.l));
    chk("sync_zero", 32'(sync_zero),                32'(g.sz));
    chk("duty_ack",  32'(duty_ack),                 32'(g.ack));
    chk("fault_lat", 32'(fault_lat),                32'(g.flat));
    highs_a += 32'(pwm_ah);
    syncs   += 32'(sync_zero);
    acks    += 32'(duty_ack);
  endtask

  task automatic check_all_zero(input string name);
    chk({name, "_pwm"}, 32'({pwm_ah, pwm_al, pwm_bh, pwm_bl, pwm_ch, pwm_cl}), 0);
    chk({name, "_cnt"}, 32'(cnt), 0);
    chk({name, "_flags"}, 32'({sync_zero, duty_ack, fault_lat}), 0);
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    highs_a     = 0;
    syncs       = 0;
    acks        = 0;
    model_reset();

    tbl[0] = '{16'd0,      0};
    tbl[1] = '{16'd1,      2};
    tbl[2] = '{16'd5,      10};
    tbl[3] = '{16'd9,      18};
    tbl[4] = '{16'd10,     20};
    tbl[5] = '{16'd15,     20};
    tbl[6] = '{16'hFFFF,   20};

    global_rst = 1'b0;
    en         = 1'b0;
    duty_a     = '0;
    duty_b     = '0;
    duty_c     = '0;
    duty_ld    = 1'b0;
    fault      = 1'b0;
    fault_clr  = 1'b0;
    #12;
    check_all_zero("reset");
    @(negedge sysclk);
    global_rst = 1'b1;

    // Constant duty per table entry, loaded while idle, two periods each.
    for (int k = 0; k < 7; k++) begin
      en      = 1'b0;
      duty_a  = tbl[k].duty;
      duty_b  = tbl[k].duty >> 1;
      duty_c  = 16'd3;
      duty_ld = 1'b1;
      tick();
      duty_ld = 1'b0;
      tick();
      en = 1'b1;
      for (int p = 0; p < 2; p++) begin
        highs_a = 0;
        repeat (PER) tick();
        chk($sformatf("vec%0d_highs_p%0d", k, p), highs_a, tbl[k].exp_highs);
      end
    end

    // Mid-period duty change 3 -> 7 at cnt = 4, up phase.
    en     = 1'b0;
    duty_a = 16'd3;
    duty_b = 16'd3;
    duty_c = 16'd3;
    duty_ld = 1'b1;
    tick();
    duty_ld = 1'b0;
    tick();
    en = 1'b1;
    highs_a = 0;
    repeat (PER) tick();
    chk("chg_first_period", highs_a, 6);
    highs_a = 0;
    acks    = 0;
    repeat (4) tick();
    chk("chg_cnt_at_load", 32'(cnt), 4);
    duty_a  = 16'd7;
    duty_ld = 1'b1;
    tick();
    duty_ld = 1'b0;
    repeat (PER - 5) tick();
    chk("chg_unchanged_period", highs_a, 6);
    chk("chg_ack_count", acks, 1);
    highs_a = 0;
    repeat (PER) tick();
    chk("chg_new_period", highs_a, 14);

    // Fault mid-pulse, clear attempts with and without fault present.
    repeat (2) tick();
    fault = 1'b1;
    tick();
    fault = 1'b0;
    chk("flt_outputs_off", 32'({pwm_ah, pwm_al, pwm_bh, pwm_bl, pwm_ch, pwm_cl}), 0);
    chk("flt_latched", 32'(fault_lat), 1);
    repeat (3) tick();
    fault     = 1'b1;
    fault_clr = 1'b1;
    tick();
    chk("flt_clr_blocked", 32'(fault_lat), 1);
    fault     = 1'b0;
    fault_clr = 1'b0;
    tick();
    fault_clr = 1'b1;
    tick();
    fault_clr = 1'b0;
    chk("flt_cleared", 32'(fault_lat), 0);
    chk("flt_still_off_on_clear", 32'({pwm_ah, pwm_al}), 0);
    tick();
    chk("flt_resumed", 32'(pwm_ah ^ pwm_al), 1);

    // sync_zero cadence, then en dropped mid-period.
    en = 1'b0;
    tick();
    en    = 1'b1;
    syncs = 0;
    repeat (2 * PER) tick();
    chk("sync_count", syncs, 2);
    repeat (7) tick();
    en = 1'b0;
    tick();
    chk("en_off_cnt", 32'(cnt), 0);
    chk("en_off_pwm", 32'({pwm_ah, pwm_al, pwm_bh, pwm_bl, pwm_ch, pwm_cl}), 0);

    // Reset mid-period with a pending duty.
    en = 1'b1;
    repeat (5) tick();
    duty_a  = 16'd9;
    duty_ld = 1'b1;
    tick();
    duty_ld = 1'b0;
    repeat (2) tick();
    #2;
    global_rst = 1'b0;
    #1;
    check_all_zero("midrst");
    model_reset();
    repeat (2) @(posedge sysclk);
    @(negedge sysclk);
    global_rst = 1'b1;
    en   = 1'b0;
    acks = 0;
    repeat (2) tick();
    chk("midrst_no_ack", acks, 0);
    en      = 1'b1;
    highs_a = 0;
    repeat (PER) tick();
    chk("midrst_active_zero", highs_a, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
